// File: rtl/ex_muldiv.sv
`default_nettype none
// ex_muldiv: iterative RISC-V M-extension multiply/divide unit (radix-2, one bit per cycle).
// Revision 1.0
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            regs_wen_o
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]      funct3;
    logic [4:0]      rd_addr;
    logic            sign1, sign2;
    logic [XLEN-1:0] hi, lo, opb;
    logic [CNT_W-1:0] cnt;

    logic            op1_signed, op2_signed, sign1_req, sign2_req;
    logic [XLEN-1:0] abs1, abs2, fast_result;
    logic            div_zero, div_ovf, fast, accept, last;

    always_comb begin
        op1_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
        op2_signed  = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sign1_req   = op1_signed & op1_i[XLEN-1];
        sign2_req   = op2_signed & op2_i[XLEN-1];
        abs1        = sign1_req ? -op1_i : op1_i;
        abs2        = sign2_req ? -op2_i : op2_i;
        div_zero    = funct3_i[2] && (op2_i == '0);
        div_ovf     = funct3_i[2] && !funct3_i[0] && (op1_i == MIN_INT) && (op2_i == '1);
        fast        = div_zero || div_ovf;
        // Divide by zero wins over overflow; both are resolved without iterating.
        if (div_zero)
            fast_result = funct3_i[1] ? op1_i : '1;
        else
            fast_result = funct3_i[1] ? '0 : MIN_INT;
        accept      = (state == IDLE) && start_i && !flush_i;
        last        = (cnt == CNT_W'(XLEN-1));
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]     mul_sum, shifted;
    logic [XLEN-1:0]   diff, hi_nxt, lo_nxt, quo, rem, calc_result;
    logic              ge, neg;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, opb};
        diff    = shifted[XLEN-1:0] - opb;
        if (funct3[2]) begin
            hi_nxt = ge ? diff : shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            {hi_nxt, lo_nxt} = {mul_sum, lo[XLEN-1:1]};
        end
        neg    = sign1 ^ sign2;
        prod   = {hi_nxt, lo_nxt};
        prod_s = neg ? -prod : prod;
        quo    = neg ? -lo_nxt : lo_nxt;
        rem    = sign1 ? -hi_nxt : hi_nxt;
        if (funct3[2])
            calc_result = funct3[1] ? rem : quo;
        else if (funct3[1:0] == 2'b00)
            calc_result = prod_s[XLEN-1:0];
        else
            calc_result = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy_o      = (state != IDLE);
        hold_flag_o = accept || (state == CALC);
        done_o      = (state == DONE) && !flush_i;
        regs_wen_o  = done_o;
        case (state)
            IDLE: if (accept) state_nxt = fast ? DONE : CALC;
            CALC: begin
                if (flush_i)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            funct3    <= '0;
            rd_addr   <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            opb       <= '0;
            cnt       <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else if (accept) begin
            funct3  <= funct3_i;
            rd_addr <= rd_addr_i;
            sign1   <= sign1_req;
            sign2   <= sign2_req;
            hi      <= '0;
            cnt     <= '0;
            // Multiply iterates over the multiplier bits; divide shifts the dividend out.
            lo      <= funct3_i[2] ? abs1 : abs2;
            opb     <= funct3_i[2] ? abs2 : abs1;
            if (fast) begin
                result_o  <= fast_result;
                rd_addr_o <= rd_addr_i;
            end
        end else if (state == CALC && !flush_i) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                result_o  <= calc_result;
                rd_addr_o <= rd_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// tb_ex_muldiv: scoreboard bench for ex_muldiv with directed and randomized operations.
// Revision 1.0
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic [4:0]      rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic            busy_o, hold_flag_o, done_o, regs_wen_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    ex_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .funct3_i(funct3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .hold_flag_o(hold_flag_o), .done_o(done_o),
        .result_o(result_o), .rd_addr_o(rd_addr_o), .regs_wen_o(regs_wen_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb_, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f3)
            3'b000: begin p = sa * sb_; return p[31:0]; end
            3'b001: begin p = sa * sb_; return p[63:32]; end
            3'b010: begin p = sa * ub;  return p[63:32]; end
            3'b011: begin p = ua * ub;  return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb_; return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb_; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (rstn && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got result %h rd %0d expected no completion (cycle %0d)",
                         result_o, rd_addr_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result_o, mon_e.res);
                chk("rd_addr", rd_addr_o, mon_e.rd);
                chk("done_cycle", cyc, mon_e.due);
                chk("regs_wen", regs_wen_o, 1);
            end
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        exp_t e;
        @(posedge clk); #1;
        funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        last_n = cyc;
        if (push) begin
            e.res = exp;
            e.rd  = rd;
            e.due = cyc + (is_fast(f3, a, b) ? 1 : XLEN + 1);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        drive(f3, a, b, rd, exp, push);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL completion_timeout: got %0d pending expected 0 (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    logic [2:0]  d_f3  [11] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                                3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] d_a   [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'd0};

    initial begin
        int          n0;
        bit          hold_ok;
        logic [31:0] r_before, a, b;
        logic [2:0]  f3;
        logic [4:0]  rd;

        // Reset state
        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_wen", regs_wen_o, 0);
        chk("reset_result", result_o, 0);
        chk("reset_rd", rd_addr_o, 0);
        @(negedge clk);
        rstn = 1'b1;

        // MUL latency and hold_flag window, plus a start ignored mid-CALC
        drive(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b1);
        n0 = last_n;
        @(negedge clk);
        chk("hold_at_start", hold_flag_o, 1);
        chk("busy_at_start", busy_o, 0);
        hold_ok = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            start_i = (k == 5);
            if (k == 5) begin
                funct3_i = 3'b011; op1_i = 32'h1234_5678; op2_i = 32'h9; rd_addr_i = 5'd30;
            end
            @(negedge clk);
            if (k <= 32 && hold_flag_o !== 1'b1) hold_ok = 1'b0;
            if (k == 33) begin
                chk("hold_low_in_done", hold_flag_o, 0);
                chk("busy_in_done", busy_o, 1);
            end
        end
        chk("hold_during_calc", hold_ok, 1);
        wait_empty(10);

        // Directed mul-high, divide, remainder and fast-path cases
        for (int i = 0; i < 11; i++) begin
            issue(d_f3[i], d_a[i], d_b[i], 5'(i + 4), d_exp[i], 1'b1);
            wait_empty(50);
        end

        // Back-to-back: second start in the cycle after DONE
        issue(3'b000, 32'h0001_2345, 32'h0000_0777, 5'd5, ref_model(3'b000, 32'h0001_2345, 32'h777), 1'b1);
        n0 = last_n;
        wait_until(n0 + 33);
        issue(3'b000, 32'hDEAD_BEEF, 32'h0000_0013, 5'd9, ref_model(3'b000, 32'hDEAD_BEEF, 32'h13), 1'b1);
        wait_empty(50);

        // Flush mid-CALC
        r_before = result_o;
        issue(3'b011, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd7, 32'd0, 1'b0);
        n0 = last_n;
        wait_until(n0 + 10);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("busy_after_flush", busy_o, 0);
        repeat (40) @(posedge clk);
        chk("result_after_flush", result_o, r_before);

        // Flush and start together in IDLE
        @(posedge clk); #1;
        funct3_i = 3'b000; op1_i = 32'd3; op2_i = 32'd4; rd_addr_i = 5'd2;
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        chk("hold_flush_start", hold_flag_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("busy_flush_start", busy_o, 0);

        // Asynchronous reset mid-CALC
        issue(3'b000, 32'h0BAD_F00D, 32'h0000_0101, 5'd11, 32'd0, 1'b0);
        n0 = last_n;
        wait_until(n0 + 20);
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_wen", regs_wen_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_rd", rd_addr_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("busy_after_reset", busy_o, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(0, 20)) - 32'd10; end
                default: ;
            endcase
            rd = 5'($urandom_range(1, 31));
            issue(f3, a, b, rd, ref_model(f3, a, b), 1'b1);
            wait_empty(50);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
